// File: rtl/stdout_buffer.sv
// Byte FIFO plus transmit sequencer feeding uart_tx from the core's stdout strobe.
// Optional macro STDOUT_BUFFER_CRLF_EN expands each LF into a CR,LF pair on the wire.
module stdout_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_strobe,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_ready,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic                  r_strobe_d;
    state_t                r_state;
`ifdef STDOUT_BUFFER_CRLF_EN
    logic                  r_cr_done;
`endif

    logic                  w_rise;
    logic                  w_send;
    logic                  w_pop;
    logic                  w_push;
    logic [7:0]            w_head;
    logic [7:0]            w_tx_byte;
    logic                  w_insert_cr;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    // Push/pop decisions; a pop in the same edge frees the slot for a push into a full FIFO.
    always_comb begin
        w_rise      = in_strobe & ~r_strobe_d;
        w_head      = r_mem[r_rd_ptr];
        w_send      = (r_state == IDLE) && !empty && tx_ready;
`ifdef STDOUT_BUFFER_CRLF_EN
        w_insert_cr = (w_head == 8'h0A) && !r_cr_done;
`else
        w_insert_cr = 1'b0;
`endif
        w_tx_byte   = w_insert_cr ? 8'h0D : w_head;
        w_pop       = w_send && !w_insert_cr;
        w_push      = w_rise && (!full || w_pop);
        w_level_nxt = level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
    end

    // Byte storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy flags, strobe history and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_strobe_d <= 1'b0;
            level      <= LVL_ZERO;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_strobe_d <= in_strobe;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            level <= w_level_nxt;
            empty <= (w_level_nxt == LVL_ZERO);
            full  <= (w_level_nxt == LVL_FULL);
            if (w_rise && !w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit sequencer: load byte and pulse start, then follow uart_tx busy/idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
`ifdef STDOUT_BUFFER_CRLF_EN
            r_cr_done <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (w_send) begin
                        tx_data   <= w_tx_byte;
                        tx_start  <= 1'b1;
                        r_state   <= START;
`ifdef STDOUT_BUFFER_CRLF_EN
                        r_cr_done <= w_insert_cr;
`endif
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    tx_start <= 1'b0;
                    if (!tx_ready) begin
                        r_state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    tx_start <= 1'b0;
                    if (tx_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_buffer.sv
// Self-checking bench for stdout_buffer: queue-based reference model plus directed scenarios.
module tb_stdout_buffer;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int FRAME = 100;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [7:0]    in_data   = 8'h00;
    logic          in_strobe = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_ready  = 1'b1;
    logic          empty;
    logic          full;
    logic [DL:0]   level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    stdout_buffer #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .empty(empty), .full(full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart_tx stand-in: goes busy for FRAME cycles after each start pulse
    int   uart_cnt  = 0;
    logic uart_hold = 1'b0;
    always @(negedge clk) begin
        if (tx_start) uart_cnt = FRAME;
        else if (uart_cnt > 0) uart_cnt--;
        tx_ready = !uart_hold && (uart_cnt == 0);
    end

    // Reference model: a byte queue, a sticky drop flag and a "transfer in flight" flag
    logic [7:0] m_q[$];
    logic [7:0] model_log[$];
    logic [7:0] dut_log[$];
    logic       m_prev = 1'b0, m_ovf = 1'b0, m_busy = 1'b0, m_seen_low = 1'b0;
    logic       m_cr = 1'b0, m_start = 1'b0, m_rise, m_can, m_pop;
    logic [7:0] m_data = 8'h00;
    int         m_age = 0;
    int         peak = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_prev = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_seen_low = 1'b0;
            m_cr = 1'b0; m_start = 1'b0; m_data = 8'h00;
        end else begin
            m_rise = in_strobe && !m_prev;
            m_prev = in_strobe;
            m_can  = !m_busy && (m_q.size() > 0) && tx_ready;
            if (m_busy) begin
                m_age++;
                if (m_age >= 2) begin
                    if (!m_seen_low) begin
                        if (!tx_ready) m_seen_low = 1'b1;
                    end else if (tx_ready) begin
                        m_busy = 1'b0;
                    end
                end
            end
            m_start = 1'b0;
            if (m_can) begin
                m_busy = 1'b1; m_age = 0; m_seen_low = 1'b0; m_start = 1'b1;
                m_pop  = 1'b1;
                m_data = m_q[0];
`ifdef STDOUT_BUFFER_CRLF_EN
                if (m_q[0] == 8'h0A && !m_cr) begin
                    m_data = 8'h0D; m_pop = 1'b0; m_cr = 1'b1;
                end else begin
                    m_cr = 1'b0;
                end
`endif
                if (m_pop) void'(m_q.pop_front());
                model_log.push_back(m_data);
            end
            if (m_rise) begin
                if (m_q.size() < DEPTH) m_q.push_back(in_data);
                else m_ovf = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("level", int'(level), m_q.size());
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tx_start", int'(tx_start), int'(m_start));
        chk("tx_data", int'(tx_data), int'(m_data));
        if (tx_start) dut_log.push_back(tx_data);
        if (int'(level) > peak) peak = int'(level);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobe_byte(input logic [7:0] b);
        in_data = b; in_strobe = 1'b1; step(1);
        in_strobe = 1'b0; step(1);
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int t = 0;
        while (dut_log.size() < n && t < budget) begin step(1); t++; end
        chk(name, dut_log.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((uart_cnt != 0 || !tx_ready || !empty) && t < 5000) begin step(1); t++; end
        chk("idle_timeout", int'(t < 5000), 1);
        step(4);
    endtask

    task automatic clear_logs();
        dut_log.delete(); model_log.delete();
    endtask

    task automatic chk_seq(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, dut_log.size(), exp.size());
        chk({name, "_model_len"}, model_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            chk(name, int'(dut_log[i]), int'(exp[i]));
        for (int i = 0; i < exp.size() && i < model_log.size(); i++)
            chk({name, "_model"}, int'(model_log[i]), int'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp[$];
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
        // reset values
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        step(2);

        // single byte: start pulse seen at the second edge after the rise
        clear_logs();
        in_data = 8'h41; in_strobe = 1'b1;
        step(1);
        chk("single_start_n", int'(tx_start), 0);
        chk("single_level_n", int'(level), 1);
        in_strobe = 1'b0;
        step(1);
        chk("single_start_n1", int'(tx_start), 1);
        chk("single_data", int'(tx_data), 8'h41);
        chk("single_empty", int'(empty), 1);
        step(1);
        chk("single_start_n2", int'(tx_start), 0);
        wait_idle();

        // held strobe writes once
        clear_logs();
        in_data = 8'h42; in_strobe = 1'b1;
        step(50);
        in_strobe = 1'b0;
        wait_idle();
        exp = '{8'h42};
        chk_seq("held", exp);

        // burst of 16 while the UART is slow
        clear_logs();
        peak = 0;
        for (int i = 0; i < 16; i++) strobe_byte(8'(i));
        chk("burst_peak", peak, 15);
        chk("burst_overflow", int'(overflow), 0);
        exp.delete();
        for (int i = 0; i < 16; i++) begin
`ifdef STDOUT_BUFFER_CRLF_EN
            if (i == 10) exp.push_back(8'h0D);
`endif
            exp.push_back(8'(i));
        end
        wait_sent(exp.size(), 3000, "burst_timeout");
        wait_idle();
        chk_seq("burst", exp);

        // reset mid-transfer while the UART is still shifting
        clear_logs();
        strobe_byte(8'h55);
        step(10);
        chk("mid_uart_busy", int'(tx_ready), 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_level", int'(level), 0);
        chk("mid_empty", int'(empty), 1);
        chk("mid_tx_data", int'(tx_data), 0);
        strobe_byte(8'h66);
        wait_sent(2, 500, "mid_timeout");
        wait_idle();
        exp = '{8'h55, 8'h66};
        chk_seq("mid", exp);

        // overflow with the UART held busy
        clear_logs();
        uart_hold = 1'b1;
        step(2);
        for (int i = 0; i < 17; i++) strobe_byte(8'h20 + 8'(i));
        chk("ovf_full", int'(full), 1);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_level", int'(level), 16);
        uart_hold = 1'b0;
        wait_sent(16, 3000, "ovf_timeout");
        wait_idle();
        step(200);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(8'h20 + 8'(i));
        chk_seq("ovf", exp);
        chk("ovf_sticky", int'(overflow), 1);

        // LF handling
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("lf_ovf_cleared", int'(overflow), 0);
        wait_idle();
        clear_logs();
        strobe_byte(8'h48);
        strobe_byte(8'h0A);
`ifdef STDOUT_BUFFER_CRLF_EN
        exp = '{8'h48, 8'h0D, 8'h0A};
`else
        exp = '{8'h48, 8'h0A};
`endif
        wait_sent(exp.size(), 1000, "lf_timeout");
        wait_idle();
        chk_seq("lf", exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
